fetch_ifid_stage: RTL and testbench
===================================

// Module: fetch_ifid_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
//   Holds the PC, drives the instruction-memory address and captures {pc, instr} into IF/ID.
//   Consumes the EX-stage branch decision (flush + beq/bne/bge/blt + target): redirects the PC and squashes IF/ID.
//   Honours the hazard unit's load-use stall.
// PARAMETERS
//   XLEN      32            datapath / PC width
//   RESET_PC  32'h0000_0000 PC value loaded on reset
//   NOP_INSTR 32'h0000_0013 bubble encoding (addi x0,x0,0) written into IF/ID on squash
// PORTS
//   clk            in   1     single clock; all state updates on posedge
//   reset          in   1     synchronous, active-high reset
//   stall          in   1     hazard unit: hold PC and IF/ID this cycle
//   flush          in   1     branch decision: taken branch in EX
//   beq,bne,bge,blt in  1 ea  branch decision: which condition fired
//   branch_target  in   XLEN  EX-computed target (pc_ex + imm)
//   imem_addr      out  XLEN  instruction-memory address (= pc, combinational)
//   imem_rdata     in   32    instruction word (combinational read, same cycle)
//   ifid_pc        out  XLEN  PC of the instruction in IF/ID
//   ifid_instr     out  32    instruction in IF/ID
//   ifid_valid     out  1     IF/ID holds a real instruction
//   redirect       out  1     combinational: taken redirect this cycle (drives the ID/EX squash)
// BEHAVIOUR
//   redirect = flush & (beq|bne|bge|blt). flush without a condition bit is ignored.
//   Priority each posedge: reset > redirect > stall > advance.
//   reset: pc<=RESET_PC; ifid_pc<=0; ifid_instr<=NOP_INSTR; ifid_valid<=0. reset mid-redirect or mid-stall wins.
//   redirect: pc<={branch_target[XLEN-1:2],2'b00} (low bits cleared); ifid_instr<=NOP_INSTR; ifid_valid<=0; ifid_pc<=0.
//     Overrides a simultaneous stall; the fetched word is discarded.
//   stall (no redirect): pc, ifid_pc, ifid_instr, ifid_valid all hold.
//   advance: ifid_pc<=pc; ifid_instr<=imem_rdata; ifid_valid<=1; pc<=pc+4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0).
//   Latency: fetched instruction visible on ifid_* one cycle after pc presents it. Redirect target appears on
//     imem_addr the cycle after redirect, and in IF/ID the cycle after that (2-cycle taken-branch penalty).
//   Back-to-back redirects: each is honoured; the later target wins.
//   imem_addr = pc at all times, including during reset and stall.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds outputs perf_redirects[31:0] and perf_stalls[31:0].
//     They reset to 0, increment on each redirect cycle and each stall-without-redirect cycle,
//     and saturate at 32'hFFFF_FFFF.
//   Not defined: ports and counters are absent; the rest of the behaviour is identical.
// STRUCTURE
//   Shared package riscv_pkg: XLEN, NOP_INSTR, RESET_PC default, PC_INC (=4).
//   Sub-module ifid_reg: the IF/ID register with reset/squash/hold/load controls.
//     The PC register and next-PC mux stay in this module.
// TESTING
//   1 reset held 2 cycles, release -> imem_addr 0,4,8 on successive cycles; ifid_valid rises 1 cycle after release.
//   2 imem_rdata=32'h00500093 at pc 8, stall high 3 cycles -> ifid holds {8,00500093}, imem_addr stays 12, then resumes at 16.
//   3 flush=1,beq=1,target=32'h40 while pc=0x1C -> next cycle imem_addr=0x40, ifid_instr=0x13, ifid_valid=0; redirect=1 that cycle.
//   4 flush=1,bne=1,target=32'h83 with stall=1 -> redirect wins: imem_addr=0x80, IF/ID squashed.
//   5 flush=1 with all condition bits 0 -> no redirect, pc advances by 4.
//   6 pc forced to 32'hFFFF_FFFC via redirect -> next advance imem_addr=0. With FETCH_PERF_CNT_EN: after tests 2-4, perf_stalls=3, perf_redirects=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core constants and IF/ID control type
//
// Contents:
//   XLEN         datapath / PC width
//   RESET_PC     default PC loaded on reset
//   NOP_INSTR    bubble encoding (addi x0,x0,0)
//   PC_INC       sequential fetch increment
//   ifid_ctrl_e  per-cycle command for the IF/ID register
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_SQUASH = 2'd2
  } ifid_ctrl_e;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// rtl/fetch_ifid_stage_if.sv - fetch stage control, imem and IF/ID signal bundle
//
// Signals:
//   stall, flush, beq/bne/bge/blt, branch_target   hazard / EX inputs to fetch
//   imem_addr, imem_rdata                           instruction-memory port
//   ifid_pc, ifid_instr, ifid_valid                 IF/ID register contents
//   redirect                                        taken redirect this cycle
//   perf_redirects, perf_stalls                     only with FETCH_PERF_CNT_EN
// Modports:
//   slave   the fetch stage
//   master  the surrounding core / environment
interface fetch_ifid_stage_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);

  logic            stall;
  logic            flush;
  logic            beq;
  logic            bne;
  logic            bge;
  logic            blt;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            redirect;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_redirects;
  logic [31:0]     perf_stalls;
`endif

  modport slave (
`ifdef FETCH_PERF_CNT_EN
    output perf_redirects,
    output perf_stalls,
`endif
    input  stall,
    input  flush,
    input  beq,
    input  bne,
    input  bge,
    input  blt,
    input  branch_target,
    output imem_addr,
    input  imem_rdata,
    output ifid_pc,
    output ifid_instr,
    output ifid_valid,
    output redirect
  );

  modport master (
`ifdef FETCH_PERF_CNT_EN
    input  perf_redirects,
    input  perf_stalls,
`endif
    output stall,
    output flush,
    output beq,
    output bne,
    output bge,
    output blt,
    output branch_target,
    input  imem_addr,
    output imem_rdata,
    input  ifid_pc,
    input  ifid_instr,
    input  ifid_valid,
    input  redirect
  );

endinterface

// File: rtl/fetch_ifid_stage_ifid_reg.sv
// rtl/fetch_ifid_stage_ifid_reg.sv - IF/ID pipeline register with reset/squash/hold/load
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   ctrl_i       HOLD keeps contents, LOAD captures pc_i/instr_i, SQUASH inserts a bubble
//   pc_i         PC of the word being fetched
//   instr_i      fetched instruction word
//   pc_o         registered PC
//   instr_o      registered instruction
//   valid_o      register holds a real instruction
module ifid_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  ifid_ctrl_e      ctrl_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (ctrl_i)
      IFID_LOAD: begin
        pc_d    = pc_i;
        instr_d = instr_i;
        valid_d = 1'b1;
      end
      IFID_SQUASH: begin
        pc_d    = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ifid_stage.sv
// rtl/fetch_ifid_stage.sv - RV32I instruction fetch stage with IF/ID register
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          fetch_ifid_stage_if.slave: stall/branch inputs, imem port, IF/ID outputs,
//                redirect, and perf counters when FETCH_PERF_CNT_EN is defined
// Configuration:
//   FETCH_PERF_CNT_EN  adds saturating perf_redirects / perf_stalls counters
// Next-cycle priority: reset > redirect > stall > advance.
module fetch_ifid_stage #(
  parameter int unsigned     XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input logic              clk,
  input logic              reset,
  fetch_ifid_stage_if.slave bus
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect;
  ifid_ctrl_e      ifid_ctrl;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;

  // A flush with no condition bit set is not a taken branch.
  assign redirect = bus.flush & (bus.beq | bus.bne | bus.bge | bus.blt);

  always_comb begin
    pc_d      = pc_q;
    ifid_ctrl = IFID_HOLD;
    if (redirect) begin
      // Targets are word aligned; low bits of the EX sum are dropped.
      pc_d      = bus.branch_target & ~XLEN'(3);
      ifid_ctrl = IFID_SQUASH;
    end else if (!bus.stall) begin
      pc_d      = pc_q + XLEN'(PC_INC);
      ifid_ctrl = IFID_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .ctrl_i  (ifid_ctrl),
    .pc_i    (pc_q),
    .instr_i (bus.imem_rdata),
    .pc_o    (ifid_pc),
    .instr_o (ifid_instr),
    .valid_o (ifid_valid)
  );

  assign bus.imem_addr  = pc_q;
  assign bus.redirect   = redirect;
  assign bus.ifid_pc    = ifid_pc;
  assign bus.ifid_instr = ifid_instr;
  assign bus.ifid_valid = ifid_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_stalls_d    = perf_stalls_q;
    if (redirect && (perf_redirects_q != 32'hFFFF_FFFF)) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
    // A stall overridden by a redirect does not count as a stall cycle.
    if (!redirect && bus.stall && (perf_stalls_q != 32'hFFFF_FFFF)) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_redirects_q <= '0;
      perf_stalls_q    <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_stalls_q    <= perf_stalls_d;
    end
  end

  assign bus.perf_redirects = perf_redirects_q;
  assign bus.perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb/tb_fetch_ifid_stage.sv - directed self-checking bench for fetch_ifid_stage
module tb_fetch_ifid_stage;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  fetch_ifid_stage_if bus ();

  // Instruction memory: address 8 holds addi x1,x0,5; every other word is addr ^ A5A50000.
  assign bus.imem_rdata = (bus.imem_addr == 32'h8) ? 32'h0050_0093
                                                   : (bus.imem_addr ^ 32'hA5A5_0000);

  fetch_ifid_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.beq           = 1'b0;
    bus.bne           = 1'b0;
    bus.bge           = 1'b0;
    bus.blt           = 1'b0;
    bus.branch_target = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    tests++; if (bus.imem_addr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, 32'h0); end
    tests++; if (bus.ifid_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", bus.ifid_valid); end
    tests++; if (bus.ifid_instr !== 32'h13) begin failed++; $display("FAIL reset_instr: got %h want %h", bus.ifid_instr, 32'h13); end
    tests++; if (bus.ifid_pc !== 32'h0) begin failed++; $display("FAIL reset_pc: got %h want %h", bus.ifid_pc, 32'h0); end
`ifdef FETCH_PERF_CNT_EN
    tests++; if (bus.perf_redirects !== 32'h0) begin failed++; $display("FAIL reset_perf_redir: got %0d want 0", bus.perf_redirects); end
    tests++; if (bus.perf_stalls !== 32'h0) begin failed++; $display("FAIL reset_perf_stall: got %0d want 0", bus.perf_stalls); end
`endif
    reset = 1'b0;
    tick();
    tests++; if (bus.imem_addr !== 32'h4) begin failed++; $display("FAIL release_addr4: got %h want %h", bus.imem_addr, 32'h4); end
    tests++; if (bus.ifid_valid !== 1'b1) begin failed++; $display("FAIL release_valid: got %b want 1", bus.ifid_valid); end
    tests++; if (bus.ifid_instr !== 32'hA5A5_0000) begin failed++; $display("FAIL release_instr: got %h want %h", bus.ifid_instr, 32'hA5A5_0000); end
    tick();
    tests++; if (bus.imem_addr !== 32'h8) begin failed++; $display("FAIL release_addr8: got %h want %h", bus.imem_addr, 32'h8); end
    tests++; if (bus.ifid_pc !== 32'h4) begin failed++; $display("FAIL release_ifid_pc: got %h want %h", bus.ifid_pc, 32'h4); end
  endtask

  task automatic test_stall();
    tick();
    tests++; if (bus.ifid_pc !== 32'h8) begin failed++; $display("FAIL stall_pre_pc: got %h want %h", bus.ifid_pc, 32'h8); end
    tests++; if (bus.ifid_instr !== 32'h0050_0093) begin failed++; $display("FAIL stall_pre_instr: got %h want %h", bus.ifid_instr, 32'h0050_0093); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.imem_addr !== 32'hC) begin failed++; $display("FAIL stall_addr[%0d]: got %h want %h", i, bus.imem_addr, 32'hC); end
      tests++; if (bus.ifid_pc !== 32'h8 || bus.ifid_instr !== 32'h0050_0093 || bus.ifid_valid !== 1'b1) begin
        failed++; $display("FAIL stall_hold[%0d]: got %h/%h/%b want 00000008/00500093/1", i, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid);
      end
    end
    bus.stall = 1'b0;
    tick();
    tests++; if (bus.imem_addr !== 32'h10) begin failed++; $display("FAIL stall_resume_addr: got %h want %h", bus.imem_addr, 32'h10); end
    tests++; if (bus.ifid_instr !== 32'hA5A5_000C) begin failed++; $display("FAIL stall_resume_instr: got %h want %h", bus.ifid_instr, 32'hA5A5_000C); end
  endtask

  task automatic test_redirect_beq();
    tick();
    tick();
    tick();
    tests++; if (bus.imem_addr !== 32'h1C) begin failed++; $display("FAIL beq_pre_addr: got %h want %h", bus.imem_addr, 32'h1C); end
    bus.flush = 1'b1;
    bus.beq = 1'b1;
    bus.branch_target = 32'h40;
    #1;
    tests++; if (bus.redirect !== 1'b1) begin failed++; $display("FAIL beq_redirect: got %b want 1", bus.redirect); end
    tick();
    clear_in();
    tests++; if (bus.imem_addr !== 32'h40) begin failed++; $display("FAIL beq_addr: got %h want %h", bus.imem_addr, 32'h40); end
    tests++; if (bus.ifid_instr !== 32'h13 || bus.ifid_valid !== 1'b0) begin
      failed++; $display("FAIL beq_squash: got %h/%b want 00000013/0", bus.ifid_instr, bus.ifid_valid);
    end
    #1;
    tests++; if (bus.redirect !== 1'b0) begin failed++; $display("FAIL beq_redirect_drop: got %b want 0", bus.redirect); end
    tick();
    tests++; if (bus.ifid_pc !== 32'h40 || bus.ifid_instr !== 32'hA5A5_0040 || bus.ifid_valid !== 1'b1) begin
      failed++; $display("FAIL beq_target_ifid: got %h/%h/%b want 00000040/a5a50040/1", bus.ifid_pc, bus.ifid_instr, bus.ifid_valid);
    end
    tests++; if (bus.imem_addr !== 32'h44) begin failed++; $display("FAIL beq_post_addr: got %h want %h", bus.imem_addr, 32'h44); end
  endtask

  task automatic test_redirect_over_stall();
    bus.flush = 1'b1;
    bus.bne = 1'b1;
    bus.stall = 1'b1;
    bus.branch_target = 32'h83;
    #1;
    tests++; if (bus.redirect !== 1'b1) begin failed++; $display("FAIL bne_redirect: got %b want 1", bus.redirect); end
    tick();
    clear_in();
    tests++; if (bus.imem_addr !== 32'h80) begin failed++; $display("FAIL bne_addr: got %h want %h", bus.imem_addr, 32'h80); end
    tests++; if (bus.ifid_instr !== 32'h13 || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 32'h0) begin
      failed++; $display("FAIL bne_squash: got %h/%h/%b want 00000000/00000013/0", bus.ifid_pc, bus.ifid_instr, bus.ifid_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    tests++; if (bus.perf_stalls !== 32'd3) begin failed++; $display("FAIL perf_stalls: got %0d want 3", bus.perf_stalls); end
    tests++; if (bus.perf_redirects !== 32'd2) begin failed++; $display("FAIL perf_redirects: got %0d want 2", bus.perf_redirects); end
`endif
  endtask

  task automatic test_flush_no_cond();
    bus.flush = 1'b1;
    bus.branch_target = 32'h200;
    #1;
    tests++; if (bus.redirect !== 1'b0) begin failed++; $display("FAIL nocond_redirect: got %b want 0", bus.redirect); end
    tick();
    clear_in();
    tests++; if (bus.imem_addr !== 32'h84) begin failed++; $display("FAIL nocond_addr: got %h want %h", bus.imem_addr, 32'h84); end
    tests++; if (bus.ifid_pc !== 32'h80 || bus.ifid_valid !== 1'b1) begin
      failed++; $display("FAIL nocond_ifid: got %h/%b want 00000080/1", bus.ifid_pc, bus.ifid_valid);
    end
  endtask

  task automatic test_wrap();
    bus.flush = 1'b1;
    bus.blt = 1'b1;
    bus.branch_target = 32'hFFFF_FFFF;
    tick();
    clear_in();
    tests++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_top: got %h want %h", bus.imem_addr, 32'hFFFF_FFFC); end
    tick();
    tests++; if (bus.imem_addr !== 32'h0) begin failed++; $display("FAIL wrap_zero: got %h want %h", bus.imem_addr, 32'h0); end
    tests++; if (bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_instr !== 32'h5A5A_FFFC) begin
      failed++; $display("FAIL wrap_ifid: got %h/%h want fffffffc/5a5afffc", bus.ifid_pc, bus.ifid_instr);
    end
  endtask

  task automatic test_back_to_back();
    bus.flush = 1'b1;
    bus.bge = 1'b1;
    bus.branch_target = 32'h100;
    tick();
    tests++; if (bus.imem_addr !== 32'h100) begin failed++; $display("FAIL b2b_first: got %h want %h", bus.imem_addr, 32'h100); end
    bus.branch_target = 32'h204;
    tick();
    clear_in();
    tests++; if (bus.imem_addr !== 32'h204 || bus.ifid_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_second: got %h/%b want 00000204/0", bus.imem_addr, bus.ifid_valid);
    end
    tick();
    tests++; if (bus.ifid_pc !== 32'h204 || bus.ifid_valid !== 1'b1 || bus.imem_addr !== 32'h208) begin
      failed++; $display("FAIL b2b_ifid: got %h/%b/%h want 00000204/1/00000208", bus.ifid_pc, bus.ifid_valid, bus.imem_addr);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    bus.flush = 1'b1;
    bus.beq = 1'b1;
    bus.stall = 1'b1;
    bus.branch_target = 32'h300;
    tick();
    tests++; if (bus.imem_addr !== 32'h0) begin failed++; $display("FAIL rstprio_addr: got %h want %h", bus.imem_addr, 32'h0); end
    tests++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h13 || bus.ifid_pc !== 32'h0) begin
      failed++; $display("FAIL rstprio_ifid: got %h/%h/%b want 00000000/00000013/0", bus.ifid_pc, bus.ifid_instr, bus.ifid_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    tests++; if (bus.perf_redirects !== 32'h0 || bus.perf_stalls !== 32'h0) begin
      failed++; $display("FAIL rstprio_perf: got %0d/%0d want 0/0", bus.perf_redirects, bus.perf_stalls);
    end
`endif
    reset = 1'b0;
    clear_in();
    tick();
    tests++; if (bus.imem_addr !== 32'h4) begin failed++; $display("FAIL rstprio_resume: got %h want %h", bus.imem_addr, 32'h4); end
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_stall();
    test_redirect_beq();
    test_redirect_over_stall();
    test_flush_no_cond();
    test_wrap();
    test_back_to_back();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
